// File: rtl/mips_ctrl_pkg.sv
// Shared definitions for the MIPS control units.
// Holds the opcode constants, the multi-cycle state encoding, the mux and
// ALU-op encodings, and the packed control word that the output decoder
// produces. The single-cycle opcode decoder uses the same opcode constants.
package mips_ctrl_pkg;

    // Instruction opcodes (IR bits [31:26])
    localparam logic [5:0] LW    = 6'b100011;
    localparam logic [5:0] SW    = 6'b101011;
    localparam logic [5:0] RTYPE = 6'b000000;
    localparam logic [5:0] ADDI  = 6'b001000;
    localparam logic [5:0] BEQ   = 6'b000100;
    localparam logic [5:0] BNE   = 6'b000101;
    localparam logic [5:0] J     = 6'b000010;

    // Multi-cycle controller states; the encodings are visible on state_dbg
    typedef enum logic [3:0] {
        IDLE     = 4'd0,
        FETCH    = 4'd1,
        DECODE   = 4'd2,
        MEMADR   = 4'd3,
        MEMREAD  = 4'd4,
        MEMWB    = 4'd5,
        MEMWRITE = 4'd6,
        EXECUTE  = 4'd7,
        ALUWB    = 4'd8,
        BRANCH   = 4'd9,
        ADDIEX   = 4'd10,
        ADDIWB   = 4'd11,
        JUMP     = 4'd12
    } state_t;

    // ALU operation requested from the ALU decoder
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    // PC source select
    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    // ALU operand B select
    localparam logic [1:0] ALUSRCB_REGB  = 2'b00;
    localparam logic [1:0] ALUSRCB_FOUR  = 2'b01;
    localparam logic [1:0] ALUSRCB_IMM   = 2'b10;
    localparam logic [1:0] ALUSRCB_IMMSH = 2'b11;

    // Full set of datapath controls for one cycle
    typedef struct packed {
        logic       iord;
        logic       irwrite;
        logic       pcwrite;
        logic       branch;
        logic       branchNe;
        logic       alusrca;
        logic       regdst;
        logic       memtoreg;
        logic       regwrite;
        logic       memread;
        logic       memwrite;
        logic [1:0] pcsrc;
        logic [1:0] alusrcb;
        logic [1:0] aluop;
    } ctrl_t;

endpackage

// File: rtl/mips_ctrl_outdec.sv
// Moore output decoder for the multi-cycle MIPS controller.
// Purely combinational: maps the registered state to the datapath control
// word. The only non-state inputs are the effective memory-ready (which
// qualifies the IR/PC writes of the accepting FETCH cycle) and a flag that
// steers the branch-compare sense in BRANCH.
// Ports:
//   state_i     - current controller state
//   mem_ready_i - memory access completes this cycle (already MEM_WAIT-qualified)
//   is_bne_i    - the instruction in the IR is bne rather than beq
//   ctrl_o      - control word for this cycle
module mips_ctrl_outdec
    import mips_ctrl_pkg::*;
(
    input  state_t     state_i,
    input  logic       mem_ready_i,
    input  logic       is_bne_i,
    output ctrl_t      ctrl_o
);

    // Every control defaults low, so IDLE and any unused encoding are inert
    always_comb begin
        ctrl_o = '0;
        case (state_i)
            FETCH: begin
                ctrl_o.memread = 1'b1;
                ctrl_o.alusrcb = ALUSRCB_FOUR;
                ctrl_o.pcsrc   = PCSRC_ALU;
                // IR and PC only capture in the cycle the fetch completes
                ctrl_o.irwrite = mem_ready_i;
                ctrl_o.pcwrite = mem_ready_i;
            end
            DECODE: begin
                ctrl_o.alusrcb = ALUSRCB_IMMSH;
            end
            MEMADR: begin
                ctrl_o.alusrca = 1'b1;
                ctrl_o.alusrcb = ALUSRCB_IMM;
            end
            MEMREAD: begin
                ctrl_o.iord    = 1'b1;
                ctrl_o.memread = 1'b1;
            end
            MEMWB: begin
                ctrl_o.regwrite = 1'b1;
                ctrl_o.memtoreg = 1'b1;
            end
            MEMWRITE: begin
                ctrl_o.iord     = 1'b1;
                ctrl_o.memwrite = 1'b1;
            end
            EXECUTE: begin
                ctrl_o.alusrca = 1'b1;
                ctrl_o.aluop   = ALUOP_FUNCT;
            end
            ALUWB: begin
                ctrl_o.regdst   = 1'b1;
                ctrl_o.regwrite = 1'b1;
            end
            BRANCH: begin
                ctrl_o.alusrca  = 1'b1;
                ctrl_o.aluop    = ALUOP_SUB;
                ctrl_o.pcsrc    = PCSRC_ALUOUT;
                ctrl_o.branch   = ~is_bne_i;
                ctrl_o.branchNe = is_bne_i;
            end
            ADDIEX: begin
                ctrl_o.alusrca = 1'b1;
                ctrl_o.alusrcb = ALUSRCB_IMM;
            end
            ADDIWB: begin
                ctrl_o.regwrite = 1'b1;
            end
            JUMP: begin
                ctrl_o.pcwrite = 1'b1;
                ctrl_o.pcsrc   = PCSRC_JUMP;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Main control unit for the multi-cycle MIPS datapath.
// Holds the state register, the next-state logic and the retired-instruction
// counter; the per-state control word comes from mips_ctrl_outdec.
// Ports:
//   clk, rst_n           - clock and asynchronous active-low reset
//   opcode               - IR bits [31:26], examined in DECODE and MEMADR
//   mem_ready            - memory access completes this cycle
//   iord .. memwrite     - single-bit datapath controls
//   pcsrc, alusrcb       - datapath mux selects
//   aluop                - operation code for the ALU decoder
//   illegal_op           - pulses in DECODE when the opcode is unknown
//   retired              - completed-instruction count (wraps)
//   state_dbg            - current state encoding
module mips_multicycle_ctrl
    import mips_ctrl_pkg::*;
#(
    parameter int OPCODE_W = 6,
    parameter int ALUOP_W  = 2,
    parameter int MEM_WAIT = 1,
    parameter int CNT_W    = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                mem_ready,
    output logic                iord,
    output logic                irwrite,
    output logic                pcwrite,
    output logic                branch,
    output logic                branch_ne,
    output logic                alusrca,
    output logic                regdst,
    output logic                memtoreg,
    output logic                regwrite,
    output logic                memread,
    output logic                memwrite,
    output logic [1:0]          pcsrc,
    output logic [1:0]          alusrcb,
    output logic [ALUOP_W-1:0]  aluop,
    output logic                illegal_op,
    output logic [CNT_W-1:0]    retired,
    output logic [3:0]          state_dbg
);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] retired_q, retired_d;
    logic             ready;
    logic             isLw, isSw, isRtype, isAddi, isBeq, isBne, isJ, isKnown;
    logic             retireEvt;
    ctrl_t            ctrl;

    // Without wait states the memory is assumed to answer every cycle
    assign ready = (MEM_WAIT == 0) ? 1'b1 : mem_ready;

    assign isLw    = (opcode == OPCODE_W'(LW));
    assign isSw    = (opcode == OPCODE_W'(SW));
    assign isRtype = (opcode == OPCODE_W'(RTYPE));
    assign isAddi  = (opcode == OPCODE_W'(ADDI));
    assign isBeq   = (opcode == OPCODE_W'(BEQ));
    assign isBne   = (opcode == OPCODE_W'(BNE));
    assign isJ     = (opcode == OPCODE_W'(J));
    assign isKnown = isLw | isSw | isRtype | isAddi | isBeq | isBne | isJ;

    // State register and retired counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            retired_q <= retired_d;
        end
    end

    // Next-state logic; memory states hold until the access completes
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:     state_d = FETCH;
            FETCH:    if (ready) state_d = DECODE;
            DECODE: begin
                if (isLw || isSw)         state_d = MEMADR;
                else if (isRtype)         state_d = EXECUTE;
                else if (isAddi)          state_d = ADDIEX;
                else if (isBeq || isBne)  state_d = BRANCH;
                else if (isJ)             state_d = JUMP;
                else                      state_d = FETCH;
            end
            // The IR is frozen outside FETCH, so the opcode still names lw/sw
            MEMADR:   state_d = isLw ? MEMREAD : MEMWRITE;
            MEMREAD:  if (ready) state_d = MEMWB;
            MEMWRITE: if (ready) state_d = FETCH;
            EXECUTE:  state_d = ALUWB;
            ADDIEX:   state_d = ADDIWB;
            MEMWB, ALUWB, ADDIWB, BRANCH, JUMP: state_d = FETCH;
            default:  state_d = IDLE;
        endcase
    end

    // An instruction retires when its last state hands back to FETCH;
    // the illegal-opcode return from DECODE deliberately does not count
    always_comb begin
        retireEvt = (state_d == FETCH) &&
                    (state_q inside {MEMWB, MEMWRITE, ALUWB, ADDIWB, BRANCH, JUMP});
        retired_d = retireEvt ? retired_q + CNT_W'(1) : retired_q;
    end

    // Output decode from the registered state
    mips_ctrl_outdec u_outdec (
        .state_i     (state_q),
        .mem_ready_i (ready),
        .is_bne_i    (isBne),
        .ctrl_o      (ctrl)
    );

    always_comb begin
        iord       = ctrl.iord;
        irwrite    = ctrl.irwrite;
        pcwrite    = ctrl.pcwrite;
        branch     = ctrl.branch;
        branch_ne  = ctrl.branchNe;
        alusrca    = ctrl.alusrca;
        regdst     = ctrl.regdst;
        memtoreg   = ctrl.memtoreg;
        regwrite   = ctrl.regwrite;
        memread    = ctrl.memread;
        memwrite   = ctrl.memwrite;
        pcsrc      = ctrl.pcsrc;
        alusrcb    = ctrl.alusrcb;
        aluop      = ALUOP_W'(ctrl.aluop);
        illegal_op = (state_q == DECODE) && !isKnown;
        retired    = retired_q;
        state_dbg  = state_q;
    end

endmodule

// File: doc/mips_multicycle_ctrl.md
# mips_multicycle_ctrl

Parametrised main control unit for the multi-cycle MIPS datapath; successor to the single-cycle opcode decoder. A registered state machine sequences each instruction through fetch, decode, execute, memory and write-back steps. It also adds bne, an optional memory wait-state handshake, an illegal-opcode flag, and a retired-instruction counter. It sits between the instruction register's opcode field and the shared multi-cycle datapath. It drives all mux selects and write enables.

## Interface
- `OPCODE_W`, 6: opcode field width.
- `ALUOP_W`, 2: ALU-op width sent to the ALU decoder.
- `MEM_WAIT`, 1: 1 = honour `mem_ready`; 0 = memory is treated as always ready.
- `CNT_W`, 32: width of the retired-instruction counter.

- `clk`, in, 1: clock. One clock; all state updates on the rising edge.
- `rst_n`, in, 1: reset, asynchronous, active-low.
- `opcode`, in, `OPCODE_W`: instruction register bits [31:26]; sampled in DECODE.
- `mem_ready`, in, 1: memory access completes this cycle.
- `iord`, `irwrite`, `pcwrite`, `branch`, `branch_ne`, `alusrca`, `regdst`, `memtoreg`, `regwrite`, `memread`, `memwrite`, out, 1 each: datapath controls.
- `pcsrc`, out, 2: 00 = ALU result, 01 = ALUOut, 10 = jump target.
- `alusrcb`, out, 2: 00 = reg B, 01 = constant 4, 10 = sign-extended immediate, 11 = sign-extended immediate << 2.
- `aluop`, out, `ALUOP_W`: 00 = add, 01 = sub, 10 = funct-decoded.
- `illegal_op`, out, 1: one-cycle pulse when an unknown opcode is decoded.
- `retired`, out, `CNT_W`: count of completed instructions.
- `state_dbg`, out, 4: current state encoding.

## Operation
- States and encodings:
  - IDLE = 0, FETCH = 1, DECODE = 2
  - MEMADR = 3, MEMREAD = 4, MEMWB = 5, MEMWRITE = 6
  - EXECUTE = 7, ALUWB = 8, BRANCH = 9
  - ADDIEX = 10, ADDIWB = 11, JUMP = 12
- Transitions:
  - IDLE → FETCH.
  - FETCH → DECODE when `mem_ready` is 1; otherwise hold in FETCH.
  - DECODE → lw/sw: MEMADR; R-type (000000): EXECUTE; addi (001000): ADDIEX; beq (000100) and bne (000101): BRANCH; j (000010): JUMP; any other opcode: FETCH with `illegal_op` = 1.
  - MEMADR → MEMREAD for lw (100011), MEMWRITE for sw (101011). Opcode is held stable by the IR, which does not update outside FETCH.
  - MEMREAD → MEMWB when ready; otherwise hold. MEMWRITE → FETCH when ready; otherwise hold.
  - EXECUTE → ALUWB; ADDIEX → ADDIWB.
  - MEMWB, ALUWB, ADDIWB, BRANCH, JUMP → FETCH.
- Outputs are Moore-decoded from the registered state. Every output not listed for a state is 0.
  - FETCH: `memread` = 1, `alusrcb` = 01, `pcsrc` = 00. `irwrite` = `pcwrite` = `mem_ready`, so they are asserted only in the accepting cycle.
  - DECODE: `alusrcb` = 11 (computes the branch target).
  - MEMADR: `alusrca` = 1, `alusrcb` = 10.
  - MEMREAD: `iord` = 1, `memread` = 1.
  - MEMWB: `regwrite` = 1, `memtoreg` = 1.
  - MEMWRITE: `iord` = 1, `memwrite` = 1.
  - EXECUTE: `alusrca` = 1, `aluop` = 10.
  - ALUWB: `regdst` = 1, `regwrite` = 1.
  - BRANCH: `alusrca` = 1, `aluop` = 01, `pcsrc` = 01. `branch` = 1 for beq; `branch_ne` = 1 for bne.
  - ADDIEX: `alusrca` = 1, `alusrcb` = 10.
  - ADDIWB: `regwrite` = 1.
  - JUMP: `pcwrite` = 1, `pcsrc` = 10.
- When `MEM_WAIT` = 0, `mem_ready` is ignored and treated as 1.
- `retired` increments by 1 on every transition into FETCH from MEMWB, MEMWRITE, ALUWB, ADDIWB, BRANCH or JUMP.
  - It wraps modulo 2^`CNT_W`.
  - The illegal-opcode path does not increment it.

## Timing
- Asynchronous reset: state = IDLE and `retired` = 0 immediately. While in IDLE, every control output and `illegal_op` is 0.
- Reset asserted mid-instruction aborts it. No write enable may be high in the cycle after `rst_n` falls.
- The first FETCH occurs in the second rising edge after `rst_n` rises.
- Cycles per instruction with zero wait states: lw 5, sw 4, R-type 4, addi 4, beq/bne 3, j 3, illegal 2.
- Each low-`mem_ready` cycle in FETCH, MEMREAD or MEMWRITE adds one cycle.
- `memread`/`memwrite` stay asserted and `iord` stays stable throughout a wait.

## Structure
- Shared package `mips_ctrl_pkg` holds:
  - opcode constants (LW, SW, RTYPE, ADDI, BEQ, BNE, J);
  - the state enum;
  - the ALUOP, PCSRC and ALUSRCB encodings.
- The single-cycle decoder reuses the same opcode constants from the package.
- One sub-module, `mips_ctrl_outdec`: purely combinational state + `mem_ready` → control word. The parent holds the state register, next-state logic and counter.

## Test plan
- Reset, then lw with `mem_ready` = 1:
  - state sequence 1, 2, 3, 4, 5, 1;
  - `regwrite` and `memtoreg` high only in MEMWB;
  - `retired` = 1.
- sw with `MEM_WAIT` = 1 and `mem_ready` low for 3 cycles in MEMWRITE: `memwrite` held high for 4 cycles with `iord` = 1; total 7 cycles.
- beq then bne: BRANCH has `aluop` = 01 and `pcsrc` = 01. `branch` = 1/`branch_ne` = 0 for beq, then the reverse for bne.
- Opcode 111111: `illegal_op` pulses for exactly 1 cycle, return to FETCH, `retired` unchanged.
- `rst_n` pulsed low during MEMREAD: outputs are 0 asynchronously, state = 0, `retired` = 0.
- `CNT_W` = 4 with 17 j instructions: `retired` wraps to 1; each j asserts `pcwrite` with `pcsrc` = 10 in JUMP.
